fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction fetch stage with IF/ID pipeline register. It sits directly upstream of the control unit.
- Holds the PC and drives the instruction-memory address. Latches the fetched word and PC+4 into IF/ID, and presents Op = IfIdInstr[31:26] to the decoder.
- Consumes the decoder's jump/Branch outputs plus the ALU Zero flag to redirect the PC. Supports stall and flush.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0000, word injected into IF/ID on flush or bubble (sll $0,$0,0).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- ImemAddr  out  32  instruction memory address; equals PC.
- ImemData  in  32  instruction word; combinational read of ImemAddr, same cycle.
- Stall  in  1  hazard unit request to hold PC and IF/ID.
- jump  in  1  from control unit; instruction in IF/ID is J.
- Branch  in  1  from control unit; instruction in IF/ID is BEQ.
- Zero  in  1  branch compare result for the instruction in IF/ID.
- PC  out  32  current fetch PC.
- IfIdInstr  out  32  registered instruction.
- IfIdPCPlus4  out  32  registered PC+4 of that instruction.
- IfIdValid  out  1  1 = IF/ID holds a real instruction, 0 = bubble.
- Op  out  6  IfIdInstr[31:26], feeds the control unit.
- Redirect  out  1  combinational; 1 when the PC is redirected this cycle.

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is synchronous and active-high.
- Reset values, taking effect on the first edge with rst=1:
  - PC = RESET_PC.
  - IfIdInstr = NOP_INSTR.
  - IfIdPCPlus4 = RESET_PC.
  - IfIdValid = 0.
  - rst overrides all other inputs.
  - Reset asserted mid-operation discards the pending redirect or stall on that edge.
- Arithmetic (all 32-bit, modulo 2^32; wrap from 32'hFFFF_FFFC to 0 is silent):
  - PCPlus4 = PC + 4.
  - BranchTarget = IfIdPCPlus4 + ({{14{IfIdInstr[15]}}, IfIdInstr[15:0], 2'b00}).
  - JumpTarget = {IfIdPCPlus4[31:28], IfIdInstr[25:0], 2'b00}.
- Redirect:
  - Redirect = IfIdValid & (jump | (Branch & Zero)).
  - jump has priority over Branch when both are 1.
  - With IfIdValid=0, jump, Branch and Zero are ignored.
- Next-state priority on each rising edge, rst=0:
  1. Redirect=1:
     - PC <= JumpTarget or BranchTarget.
     - IfIdInstr <= NOP_INSTR, IfIdValid <= 0, IfIdPCPlus4 <= PCPlus4.
     - Redirect wins over Stall: a resolved control transfer is never held.
  2. Stall=1:
     - PC, IfIdInstr, IfIdPCPlus4 and IfIdValid all hold.
     - ImemAddr stays stable.
  3. Otherwise:
     - PC <= PCPlus4.
     - IfIdInstr <= ImemData, IfIdPCPlus4 <= PCPlus4, IfIdValid <= 1.
- Branch timing:
  - Latency: a fetched word appears on IfIdInstr/Op one cycle after ImemAddr presents it.
  - Taken-branch/jump penalty: exactly one bubble cycle. The slot after the branch is squashed; no delay slot.
- Internal states: the pipeline-register state is RESET → RUN, or BUBBLE after flush.
  - BUBBLE lasts one cycle unless Stall is held.
  - A stalled bubble stays a bubble with IfIdValid=0.
- Op and ImemAddr are pure wires from the registers.
- No combinational path exists from ImemData to any output.

Test Plan:
- Sequential fetch: ROM[0]=32'h2008_0005, ROM[4]=32'h2009_0003; rst 1 cycle then run 3 cycles.
  - Required: PC 0→4→8→C.
  - IfIdInstr = 2008_0005 then 2009_0003.
  - IfIdPCPlus4 = 4 then 8.
  - IfIdValid goes 0→1.
- Stall: assert Stall for 2 cycles while PC=8.
  - Required: PC, IfIdInstr and IfIdValid unchanged for both cycles.
  - Resumes at PC=C on release.
- Taken BEQ: IfIdInstr=32'h1000_0003, IfIdPCPlus4=32'h10, Branch=1, Zero=1.
  - Required: Redirect=1, next PC=32'h1C, next IfIdValid=0, IfIdInstr=0.
  - The valid instruction from 32'h1C appears one cycle later.
- Not-taken / negative offset:
  - Branch=1, Zero=0 → PC increments normally, no bubble.
  - Offset 16'hFFFF with Zero=1 and IfIdPCPlus4=32'h20 → PC=32'h1C.
- Jump with Stall=1 simultaneously:
  - IfIdInstr=32'h0800_0040, IfIdPCPlus4=32'h4000_0008.
  - Required: PC=32'h4000_0100 despite Stall; bubble inserted.
- Reset mid-run:
  - rst asserted for one edge together with Redirect=1 at PC=32'h30.
  - Required: PC=RESET_PC, IfIdValid=0, IfIdInstr=0; redirect discarded.
  - Jump with IfIdValid=0 → ignored.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register plus the IF/ID pipeline register.
// Redirects on jump / taken branch (one squashed slot), holds on Stall, flushes to a bubble.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] ImemAddr,
  input  logic [31:0] ImemData,
  input  logic        Stall,
  input  logic        jump,
  input  logic        Branch,
  input  logic        Zero,
  output logic [31:0] PC,
  output logic [31:0] IfIdInstr,
  output logic [31:0] IfIdPCPlus4,
  output logic        IfIdValid,
  output logic [5:0]  Op,
  output logic        Redirect
);

  typedef enum logic [1:0] {
    S_RESET  = 2'd0,
    S_RUN    = 2'd1,
    S_BUBBLE = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pcp4_q, pcp4_d;

  logic [31:0] pc_plus4;
  logic [31:0] br_off;
  logic [31:0] br_tgt;
  logic [31:0] jmp_tgt;
  logic        valid;
  logic        redirect;

  assign pc_plus4 = pc_q + 32'd4;
  assign br_off   = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
  assign br_tgt   = pcp4_q + br_off;
  assign jmp_tgt  = {pcp4_q[31:28], instr_q[25:0], 2'b00};

  // Only a real instruction in IF/ID may steer the PC; bubbles ignore control inputs.
  assign valid    = (state_q == S_RUN);
  assign redirect = valid & (jump | (Branch & Zero));

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    pcp4_d  = pcp4_q;
    if (redirect) begin
      // Redirect beats Stall: the wrong-path slot is squashed rather than held.
      pc_d    = jump ? jmp_tgt : br_tgt;
      instr_d = NOP_INSTR;
      pcp4_d  = pc_plus4;
      state_d = S_BUBBLE;
    end else if (!Stall) begin
      pc_d    = pc_plus4;
      instr_d = ImemData;
      pcp4_d  = pc_plus4;
      state_d = S_RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_RESET;
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
      pcp4_q  <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pcp4_q  <= pcp4_d;
    end
  end

  assign ImemAddr    = pc_q;
  assign PC          = pc_q;
  assign IfIdInstr   = instr_q;
  assign IfIdPCPlus4 = pcp4_q;
  assign IfIdValid   = valid;
  assign Op          = instr_q[31:26];
  assign Redirect    = redirect;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: main instance on a small ROM, plus a second
// instance reset high in memory to exercise jump-with-stall near 0x4000_0000.
module tb_fetch_stage;
  logic        clk = 1'b0;
  logic        rst, rst_b;
  logic        Stall, jump, Branch, Zero;
  logic [31:0] ImemAddr, ImemData, PC, IfIdInstr, IfIdPCPlus4;
  logic        IfIdValid, Redirect;
  logic [5:0]  Op;
  logic [31:0] ImemAddr_b, PC_b, IfIdInstr_b, IfIdPCPlus4_b;
  logic        IfIdValid_b, Redirect_b;
  logic [5:0]  Op_b;
  logic [31:0] rom [0:63];
  int          n_chk = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  assign ImemData = rom[ImemAddr[7:2]];

  fetch_stage u_dut (
    .clk(clk), .rst(rst), .ImemAddr(ImemAddr), .ImemData(ImemData),
    .Stall(Stall), .jump(jump), .Branch(Branch), .Zero(Zero),
    .PC(PC), .IfIdInstr(IfIdInstr), .IfIdPCPlus4(IfIdPCPlus4),
    .IfIdValid(IfIdValid), .Op(Op), .Redirect(Redirect)
  );

  fetch_stage #(.RESET_PC(32'h4000_0004)) u_dut_b (
    .clk(clk), .rst(rst_b), .ImemAddr(ImemAddr_b), .ImemData(32'h0800_0040),
    .Stall(Stall), .jump(jump), .Branch(Branch), .Zero(Zero),
    .PC(PC_b), .IfIdInstr(IfIdInstr_b), .IfIdPCPlus4(IfIdPCPlus4_b),
    .IfIdValid(IfIdValid_b), .Op(Op_b), .Redirect(Redirect_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_if(input string tag, input logic [31:0] pc, input logic [31:0] ins,
                        input logic [31:0] p4, input logic v);
    check({tag, ".pc"},    PC, pc);
    check({tag, ".addr"},  ImemAddr, pc);
    check({tag, ".instr"}, IfIdInstr, ins);
    check({tag, ".pcp4"},  IfIdPCPlus4, p4);
    check({tag, ".valid"}, {31'd0, IfIdValid}, {31'd0, v});
  endtask

  task automatic chk_b(input string tag, input logic [31:0] pc, input logic [31:0] ins,
                       input logic [31:0] p4, input logic v);
    check({tag, ".pc"},    PC_b, pc);
    check({tag, ".instr"}, IfIdInstr_b, ins);
    check({tag, ".pcp4"},  IfIdPCPlus4_b, p4);
    check({tag, ".valid"}, {31'd0, IfIdValid_b}, {31'd0, v});
  endtask

  initial begin
    for (int i = 0; i < 64; i++) rom[i] = 32'h0000_0000;
    rom[0]  = 32'h2008_0005;
    rom[1]  = 32'h2009_0003;
    rom[2]  = 32'h0800_000C;  // J 0x30
    rom[3]  = 32'h1000_0003;  // BEQ +3
    rom[7]  = 32'h1000_FFFF;  // BEQ -1
    rom[8]  = 32'h0800_0040;  // J 0x100
    rom[12] = 32'h2010_0030;

    rst = 1; rst_b = 1; Stall = 0; jump = 0; Branch = 0; Zero = 0;
    step();
    chk_if("reset", 32'h0, 32'h0, 32'h0, 1'b0);

    // sequential fetch
    rst = 0;
    step(); chk_if("seq1", 32'h4, 32'h2008_0005, 32'h4, 1'b1);
    check("seq1.op", {26'd0, Op}, 32'h08);
    step(); chk_if("seq2", 32'h8, 32'h2009_0003, 32'h8, 1'b1);

    // stall two cycles at PC=8
    Stall = 1;
    step(); chk_if("stall1", 32'h8, 32'h2009_0003, 32'h8, 1'b1);
    step(); chk_if("stall2", 32'h8, 32'h2009_0003, 32'h8, 1'b1);
    Stall = 0;
    step(); chk_if("resume", 32'hC, 32'h0800_000C, 32'hC, 1'b1);

    // taken BEQ +3 from IfIdPCPlus4=0x10
    step(); chk_if("beq.fetch", 32'h10, 32'h1000_0003, 32'h10, 1'b1);
    check("beq.op", {26'd0, Op}, 32'h04);
    Branch = 1; Zero = 1; #1;
    check("beq.redir", {31'd0, Redirect}, 32'd1);
    step(); chk_if("beq.taken", 32'h1C, 32'h0, 32'h14, 1'b0);
    check("bubble.redir", {31'd0, Redirect}, 32'd0);
    Branch = 0; Zero = 0;
    step(); chk_if("beq.tgt", 32'h20, 32'h1000_FFFF, 32'h20, 1'b1);

    // negative offset, taken
    Branch = 1; Zero = 1; #1;
    check("neg.redir", {31'd0, Redirect}, 32'd1);
    step(); chk_if("neg.taken", 32'h1C, 32'h0, 32'h24, 1'b0);
    Branch = 0; Zero = 0;
    step(); chk_if("neg.tgt", 32'h20, 32'h1000_FFFF, 32'h20, 1'b1);

    // not taken
    Branch = 1; Zero = 0; #1;
    check("nt.redir", {31'd0, Redirect}, 32'd0);
    step(); chk_if("nt", 32'h24, 32'h0800_0040, 32'h24, 1'b1);

    // jump with simultaneous stall
    Branch = 0; jump = 1; Stall = 1; #1;
    check("jst.redir", {31'd0, Redirect}, 32'd1);
    step(); chk_if("jst", 32'h100, 32'h0, 32'h28, 1'b0);
    jump = 0; Stall = 0;
    step(); chk_if("jst.tgt", 32'h104, 32'h2008_0005, 32'h104, 1'b1);
    step(); chk_if("run1", 32'h108, 32'h2009_0003, 32'h108, 1'b1);
    step(); chk_if("run2", 32'h10C, 32'h0800_000C, 32'h10C, 1'b1);
    jump = 1;
    step(); chk_if("j30", 32'h30, 32'h0, 32'h110, 1'b0);
    jump = 0;
    step(); chk_if("j30.tgt", 32'h34, 32'h2010_0030, 32'h34, 1'b1);

    // reset together with a pending redirect
    jump = 1; #1;
    check("rstj.redir", {31'd0, Redirect}, 32'd1);
    rst = 1;
    step(); chk_if("rst.mid", 32'h0, 32'h0, 32'h0, 1'b0);
    rst = 0; #1;
    check("inv.redir", {31'd0, Redirect}, 32'd0);
    step(); chk_if("inv.jump", 32'h4, 32'h2008_0005, 32'h4, 1'b1);
    jump = 0;

    // second instance: jump from IfIdPCPlus4=0x4000_0008 under stall
    rst = 1; rst_b = 1;
    step(); chk_b("b.reset", 32'h4000_0004, 32'h0, 32'h4000_0004, 1'b0);
    rst_b = 0;
    step(); chk_b("b.fetch", 32'h4000_0008, 32'h0800_0040, 32'h4000_0008, 1'b1);
    jump = 1; Stall = 1; #1;
    check("b.redir", {31'd0, Redirect_b}, 32'd1);
    step(); chk_b("b.jst", 32'h4000_0100, 32'h0, 32'h4000_000C, 1'b0);
    jump = 0;
    step(); chk_b("b.stallbub", 32'h4000_0100, 32'h0, 32'h4000_000C, 1'b0);
    Stall = 0;
    step(); chk_b("b.resume", 32'h4000_0104, 32'h0800_0040, 32'h4000_0104, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
